// File: rtl/jtag_l2_pkg.sv
// Shared definitions for the JTAG L2 test memory: IR opcodes, TAP states,
// MEMREG field layout and the default IDCODE.
// Pure declarations; no ports, no timing.
package jtag_l2_pkg;

   localparam int unsigned IR_WIDTH = 4;

   localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 4'b0010;
   localparam logic [IR_WIDTH-1:0] IR_MEMREG  = 4'b0100;
   localparam logic [IR_WIDTH-1:0] IR_CONFREG = 4'b0110;
   localparam logic [IR_WIDTH-1:0] IR_BYPASS  = 4'b1111;
   // Fixed pattern seen on tdo during Shift-IR; the low "01" lets a probe
   // find the start of the IR chain.
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

   localparam logic [31:0] IDCODE_DEFAULT = 32'h1010_2001;

   // MEMREG: [31:0] data, [63:32] byte address, [64] write enable
   localparam int unsigned MEMREG_DATA_LSB = 0;
   localparam int unsigned MEMREG_ADDR_LSB = 32;
   localparam int unsigned MEMREG_WE_BIT   = 64;
   localparam int unsigned MEMREG_WIDTH    = 65;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } memreg_t;

   // Test-Logic-Reset is encoded as zero so an unreset state register
   // powers up in the reset state in practice.
   typedef enum logic [3:0] {
      TAP_TLR        = 4'd0,
      TAP_RTI        = 4'd1,
      TAP_SEL_DR     = 4'd2,
      TAP_CAP_DR     = 4'd3,
      TAP_SHIFT_DR   = 4'd4,
      TAP_EX1_DR     = 4'd5,
      TAP_PAUSE_DR   = 4'd6,
      TAP_EX2_DR     = 4'd7,
      TAP_UPD_DR     = 4'd8,
      TAP_SEL_IR     = 4'd9,
      TAP_CAP_IR     = 4'd10,
      TAP_SHIFT_IR   = 4'd11,
      TAP_EX1_IR     = 4'd12,
      TAP_PAUSE_IR   = 4'd13,
      TAP_EX2_IR     = 4'd14,
      TAP_UPD_IR     = 4'd15
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS  = 2'd0,
      DR_IDCODE  = 2'd1,
      DR_MEMREG  = 2'd2,
      DR_CONFREG = 2'd3
   } dr_sel_e;

   // Undefined opcodes fall back to the 1-bit bypass register.
   function automatic dr_sel_e decode_ir(input logic [IR_WIDTH-1:0] ir);
      dr_sel_e sel;
      case (ir)
         IR_IDCODE:  sel = DR_IDCODE;
         IR_MEMREG:  sel = DR_MEMREG;
         IR_CONFREG: sel = DR_CONFREG;
         default:    sel = DR_BYPASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/jtag_l2_tap.sv
// IEEE 1149.1 TAP controller oversampled in clk_i: pin synchronizers, 16-state FSM, IR, tdo.
// Latency: FSM acts 3 clk_i after a tck edge reaches the pins; no backpressure (tck paced by the probe).
// Ports: clk_i/rst_i system; jtag_* pins; dr_tdo_i LSB of selected DR; tdi_o, tlr_o, *_dr_o strobes, ir_o to the DR side.
module jtag_l2_tap
   import jtag_l2_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                jtag_tck_i,
   input  logic                jtag_trst_ni,
   input  logic                jtag_tms_i,
   input  logic                jtag_tdi_i,
   input  logic                dr_tdo_i,
   output logic                jtag_tdo_o,
   output logic                tdi_o,
   output logic                tlr_o,
   output logic                capture_dr_o,
   output logic                shift_dr_o,
   output logic                update_dr_o,
   output logic [IR_WIDTH-1:0] ir_o
);

   // [0],[1] synchronize, [2] is the previous synchronized tck for edge detect
   logic [2:0] tck_q;
   logic [1:0] tms_q;
   logic [1:0] tdi_q;
   logic [1:0] trst_q;

   always_ff @(posedge clk_i) begin
      tck_q  <= {tck_q[1:0], jtag_tck_i};
      tms_q  <= {tms_q[0], jtag_tms_i};
      tdi_q  <= {tdi_q[0], jtag_tdi_i};
      trst_q <= {trst_q[0], jtag_trst_ni};
   end

   logic tck_rise, tck_fall, tms_s, tdi_s, trst_ns;
   assign tck_rise = tck_q[1] & ~tck_q[2];
   assign tck_fall = ~tck_q[1] & tck_q[2];
   assign tms_s    = tms_q[1];
   assign tdi_s    = tdi_q[1];
   assign trst_ns  = trst_q[1];

   tap_state_e state_q, state_d;

   always_ff @(posedge clk_i) begin
      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!trst_ns) begin
         state_d = TAP_TLR;
      end else if (tck_rise) begin
         case (state_q)
            TAP_TLR:      state_d = tms_s ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms_s ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_d = tms_s ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_EX1_DR:   state_d = tms_s ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms_s ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms_s ? TAP_UPD_DR : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms_s ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms_s ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_d = tms_s ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_EX1_IR:   state_d = tms_s ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms_s ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms_s ? TAP_UPD_IR : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
         endcase
      end
   end

   // Capture/Update act on state entry; Shift acts on every rise taken
   // while sitting in Shift, which includes the rise that leaves it.
   logic cap_ir, shift_ir, upd_ir;
   assign cap_ir       = tck_rise & (state_d == TAP_CAP_IR);
   assign shift_ir     = tck_rise & (state_q == TAP_SHIFT_IR);
   assign upd_ir       = tck_rise & (state_d == TAP_UPD_IR);
   assign capture_dr_o = tck_rise & (state_d == TAP_CAP_DR);
   assign shift_dr_o   = tck_rise & (state_q == TAP_SHIFT_DR);
   assign update_dr_o  = tck_rise & (state_d == TAP_UPD_DR);
   assign tlr_o        = (state_q == TAP_TLR) | ~trst_ns;
   assign tdi_o        = tdi_s;

   logic [IR_WIDTH-1:0] ir_q, ir_sr_q;

   always_ff @(posedge clk_i) begin
      if (tlr_o) begin
         ir_q <= IR_IDCODE;
      end else if (upd_ir) begin
         ir_q <= ir_sr_q;
      end
      if (cap_ir) begin
         ir_sr_q <= IR_CAPTURE;
      end else if (shift_ir) begin
         ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
      end
   end

   assign ir_o = ir_q;

   // tdo changes on the falling tck so it is stable at the probe's next rise
   logic tdo_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tdo_q <= 1'b0;
      end else if (tck_fall) begin
         case (state_q)
            TAP_SHIFT_IR: tdo_q <= ir_sr_q[0];
            TAP_SHIFT_DR: tdo_q <= dr_tdo_i;
            default:      tdo_q <= 1'b0;
         endcase
      end
   end

   assign jtag_tdo_o = tdo_q;

endmodule

// File: rtl/jtag_l2_test.sv
// JTAG-accessible L2 test memory: TAP plus BYPASS/IDCODE/CONFREG/MEMREG data registers over a word SRAM.
// Latency: memory write/read-capture in the clk_i cycle of Update-DR/Capture-DR entry; no backpressure.
// Ports: clk_i, rst_i (sync, active-high); jtag_tck_i, jtag_trst_ni, jtag_tms_i, jtag_tdi_i in; jtag_tdo_o out.
module jtag_l2_test
   import jtag_l2_pkg::*;
#(
   parameter logic [31:0] IDCODE_VALUE = IDCODE_DEFAULT,
   parameter int unsigned MEM_WORDS    = 256,
   parameter int unsigned CONF_WIDTH   = 9
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic jtag_tck_i,
   input  logic jtag_trst_ni,
   input  logic jtag_tms_i,
   input  logic jtag_tdi_i,
   output logic jtag_tdo_o
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   logic                tdi, tlr, cap_dr, shift_dr, upd_dr, dr_tdo;
   logic [IR_WIDTH-1:0] ir;
   dr_sel_e             dr_sel;

   jtag_l2_tap u_tap (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .jtag_tck_i   (jtag_tck_i),
      .jtag_trst_ni (jtag_trst_ni),
      .jtag_tms_i   (jtag_tms_i),
      .jtag_tdi_i   (jtag_tdi_i),
      .dr_tdo_i     (dr_tdo),
      .jtag_tdo_o   (jtag_tdo_o),
      .tdi_o        (tdi),
      .tlr_o        (tlr),
      .capture_dr_o (cap_dr),
      .shift_dr_o   (shift_dr),
      .update_dr_o  (upd_dr),
      .ir_o         (ir)
   );

   assign dr_sel = decode_ir(ir);

   logic                    bypass_sr_q;
   logic [31:0]             idcode_sr_q;
   logic [CONF_WIDTH-1:0]   conf_sr_q, confreg_q;
   logic [MEMREG_WIDTH-1:0] mem_sr_q;

   logic [31:0]             mem_q [MEM_WORDS];
   logic [31:0]             rd_addr_q;
   logic                    rd_vld_q;
   logic [IDX_W-1:0]        wr_idx, rd_idx;
   memreg_t                 mem_cap;

   // Word index from the byte address; bits above the array depth alias.
   assign wr_idx = mem_sr_q[MEMREG_ADDR_LSB + 2 +: IDX_W];
   assign rd_idx = rd_addr_q[2 +: IDX_W];

   always_comb begin
      mem_cap = '0;
      if (rd_vld_q) begin
         mem_cap.addr = rd_addr_q;
         mem_cap.data = mem_q[rd_idx];
      end
   end

   // Only the selected data register captures or shifts.
   always_ff @(posedge clk_i) begin
      if (cap_dr) begin
         case (dr_sel)
            DR_BYPASS:  bypass_sr_q <= 1'b0;
            DR_IDCODE:  idcode_sr_q <= IDCODE_VALUE;
            DR_MEMREG:  mem_sr_q    <= mem_cap;
            DR_CONFREG: conf_sr_q   <= confreg_q;
            default:    bypass_sr_q <= 1'b0;
         endcase
      end else if (shift_dr) begin
         case (dr_sel)
            DR_BYPASS:  bypass_sr_q <= tdi;
            DR_IDCODE:  idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
            DR_MEMREG:  mem_sr_q    <= {tdi, mem_sr_q[MEMREG_WIDTH-1:1]};
            DR_CONFREG: conf_sr_q   <= {tdi, conf_sr_q[CONF_WIDTH-1:1]};
            default:    bypass_sr_q <= tdi;
         endcase
      end
   end

   always_comb begin
      dr_tdo = bypass_sr_q;
      case (dr_sel)
         DR_IDCODE:  dr_tdo = idcode_sr_q[0];
         DR_MEMREG:  dr_tdo = mem_sr_q[0];
         DR_CONFREG: dr_tdo = conf_sr_q[0];
         default:    dr_tdo = bypass_sr_q;
      endcase
   end

   // The configuration word belongs to the JTAG domain: only TAP reset
   // clears it, so it can be programmed while the system is held in reset.
   always_ff @(posedge clk_i) begin
      if (tlr) begin
         confreg_q <= '0;
      end else if (upd_dr && (dr_sel == DR_CONFREG)) begin
         confreg_q <= conf_sr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (upd_dr && (dr_sel == DR_MEMREG) && mem_sr_q[MEMREG_WE_BIT] && !rst_i) begin
         mem_q[wr_idx] <= mem_sr_q[MEMREG_DATA_LSB +: 32];
      end
   end

   // A latched read address stays valid for every later MEMREG capture
   // until replaced or cleared by system reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_vld_q <= 1'b0;
      end else if (upd_dr && (dr_sel == DR_MEMREG) && !mem_sr_q[MEMREG_WE_BIT]) begin
         rd_vld_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && upd_dr && (dr_sel == DR_MEMREG) && !mem_sr_q[MEMREG_WE_BIT]) begin
         rd_addr_q <= mem_sr_q[MEMREG_ADDR_LSB +: 32];
      end
   end

endmodule

// File: tb/tb_jtag_l2_test.sv
module tb_jtag_l2_test;

   logic clk_i        = 1'b0;
   logic rst_i        = 1'b1;
   logic jtag_tck_i   = 1'b0;
   logic jtag_trst_ni = 1'b1;
   logic jtag_tms_i   = 1'b1;
   logic jtag_tdi_i   = 1'b0;
   logic jtag_tdo_o;

   int checks   = 0;
   int failures = 0;

   jtag_l2_test dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .jtag_tck_i   (jtag_tck_i),
      .jtag_trst_ni (jtag_trst_ni),
      .jtag_tms_i   (jtag_tms_i),
      .jtag_tdi_i   (jtag_tdi_i),
      .jtag_tdo_o   (jtag_tdo_o)
   );

   always #5 clk_i = ~clk_i;

   // One tck period of 10 clk_i; returns tdo as seen just before the next rise.
   task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo);
      jtag_tms_i = tms;
      jtag_tdi_i = tdi;
      repeat (2) @(negedge clk_i);
      jtag_tck_i = 1'b1;
      repeat (4) @(negedge clk_i);
      jtag_tck_i = 1'b0;
      repeat (4) @(negedge clk_i);
      tdo = jtag_tdo_o;
   endtask

   task automatic tap_reset();
      logic t;
      jtag_trst_ni = 1'b0;
      repeat (4) @(negedge clk_i);
      jtag_trst_ni = 1'b1;
      repeat (4) @(negedge clk_i);
      for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
   endtask

   // Run-Test/Idle -> Shift-IR -> Update-IR -> Run-Test/Idle
   task automatic shift_ir(input logic [3:0] val, output logic [3:0] cap);
      logic t;
      tck_pulse(1'b1, 1'b0, t);
      tck_pulse(1'b1, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
      for (int i = 0; i < 4; i++) begin
         cap[i] = t;
         tck_pulse(i == 3, val[i], t);
      end
      tck_pulse(1'b1, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
   endtask

   // Run-Test/Idle -> Shift-DR (n bits) -> Update-DR -> Run-Test/Idle
   task automatic shift_dr(input int n, input logic [64:0] din, output logic [64:0] dout);
      logic t;
      dout = '0;
      tck_pulse(1'b1, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
      for (int i = 0; i < n; i++) begin
         dout[i] = t;
         tck_pulse(i == n - 1, din[i], t);
      end
      tck_pulse(1'b1, 1'b0, t);
      tck_pulse(1'b0, 1'b0, t);
   endtask

   function automatic logic [64:0] mreg(input logic we, input logic [31:0] addr, input logic [31:0] data);
      return {we, addr, data};
   endfunction

   task automatic test_reset();
      logic [64:0] d;
      logic [3:0]  c;
      repeat (6) @(negedge clk_i);
      checks++;
      if (jtag_tdo_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_tdo got=%b exp=0", jtag_tdo_o);
      end
      rst_i = 1'b0;
      tap_reset();
      shift_dr(32, '0, d);
      checks++;
      if (d[31:0] !== 32'h1010_2001) begin
         failures++;
         $display("FAIL idcode_after_tlr got=%h exp=10102001", d[31:0]);
      end
      shift_ir(4'b1111, c);
      checks++;
      if (c !== 4'b0101) begin
         failures++;
         $display("FAIL ir_capture got=%b exp=0101", c);
      end
      // trst alone must bring IR back to IDCODE
      jtag_trst_ni = 1'b0;
      repeat (4) @(negedge clk_i);
      jtag_trst_ni = 1'b1;
      repeat (4) @(negedge clk_i);
      tck_pulse(1'b0, 1'b0, c[0]);
      shift_dr(32, '0, d);
      checks++;
      if (d[31:0] !== 32'h1010_2001) begin
         failures++;
         $display("FAIL idcode_after_trst got=%h exp=10102001", d[31:0]);
      end
   endtask

   task automatic test_bypass(input logic [3:0] op);
      logic [64:0] d;
      logic [3:0]  c;
      shift_ir(op, c);
      shift_dr(9, {56'h0, 9'h0A5}, d);
      checks++;
      if (d[0] !== 1'b0) begin
         failures++;
         $display("FAIL bypass_first_bit ir=%b got=%b exp=0", op, d[0]);
      end
      checks++;
      if (d[8:1] !== 8'hA5) begin
         failures++;
         $display("FAIL bypass_data ir=%b got=%h exp=a5", op, d[8:1]);
      end
   endtask

   task automatic test_confreg();
      logic [64:0] d;
      logic [3:0]  c;
      rst_i = 1'b1;
      shift_ir(4'b0110, c);
      shift_dr(9, {56'h0, 9'h002}, d);
      checks++;
      if (d[8:0] !== 9'h000) begin
         failures++;
         $display("FAIL conf_tdo_in_rst got=%h exp=000", d[8:0]);
      end
      rst_i = 1'b0;
      shift_dr(9, {56'h0, 9'h1A5}, d);
      checks++;
      if (d[8:0] !== 9'h002) begin
         failures++;
         $display("FAIL conf_readback got=%h exp=002", d[8:0]);
      end
      shift_dr(9, '0, d);
      checks++;
      if (d[8:0] !== 9'h1A5) begin
         failures++;
         $display("FAIL conf_readback2 got=%h exp=1a5", d[8:0]);
      end
      tap_reset();
      shift_ir(4'b0110, c);
      shift_dr(9, '0, d);
      checks++;
      if (d[8:0] !== 9'h000) begin
         failures++;
         $display("FAIL conf_tlr_clear got=%h exp=000", d[8:0]);
      end
   endtask

   task automatic test_mem_rw();
      logic [64:0] d;
      logic [3:0]  c;
      shift_ir(4'b0100, c);
      shift_dr(65, mreg(1'b1, 32'h0, 32'hABBA_ABBA), d);
      checks++;
      if (d !== 65'h0) begin
         failures++;
         $display("FAIL mem_no_latch got=%h exp=0", d);
      end
      shift_dr(65, mreg(1'b0, 32'h0, 32'h0), d);
      shift_dr(65, mreg(1'b0, 32'h0, 32'h0), d);
      checks++;
      if (d !== mreg(1'b0, 32'h0, 32'hABBA_ABBA)) begin
         failures++;
         $display("FAIL mem_read0 got=%h exp=%h", d, mreg(1'b0, 32'h0, 32'hABBA_ABBA));
      end
   endtask

   task automatic test_mem_alias_rst();
      logic [64:0] d;
      shift_dr(65, mreg(1'b1, 32'h400, 32'h1234_5678), d);
      shift_dr(65, mreg(1'b0, 32'h0, 32'h0), d);
      shift_dr(65, mreg(1'b1, 32'h14, 32'hCAFE_F00D), d);
      checks++;
      if (d !== mreg(1'b0, 32'h0, 32'h1234_5678)) begin
         failures++;
         $display("FAIL mem_alias0 got=%h exp=%h", d, mreg(1'b0, 32'h0, 32'h1234_5678));
      end
      shift_dr(65, mreg(1'b0, 32'h14, 32'h0), d);
      shift_dr(65, mreg(1'b0, 32'h400, 32'h0), d);
      checks++;
      if (d !== mreg(1'b0, 32'h14, 32'hCAFE_F00D)) begin
         failures++;
         $display("FAIL mem_idx5 got=%h exp=%h", d, mreg(1'b0, 32'h14, 32'hCAFE_F00D));
      end
      shift_dr(65, mreg(1'b0, 32'h0, 32'h0), d);
      checks++;
      if (d !== mreg(1'b0, 32'h400, 32'h1234_5678)) begin
         failures++;
         $display("FAIL mem_alias400 got=%h exp=%h", d, mreg(1'b0, 32'h400, 32'h1234_5678));
      end
      rst_i = 1'b1;
      shift_dr(65, mreg(1'b1, 32'h0, 32'hDEAD_BEEF), d);
      rst_i = 1'b0;
      shift_dr(65, mreg(1'b0, 32'h0, 32'h0), d);
      checks++;
      if (d !== 65'h0) begin
         failures++;
         $display("FAIL mem_rst_clears_read got=%h exp=0", d);
      end
      shift_dr(65, mreg(1'b0, 32'h0, 32'h0), d);
      checks++;
      if (d !== mreg(1'b0, 32'h0, 32'h1234_5678)) begin
         failures++;
         $display("FAIL mem_write_in_rst got=%h exp=%h", d, mreg(1'b0, 32'h0, 32'h1234_5678));
      end
   endtask

   task automatic test_back_to_back();
      logic [64:0] d;
      logic [3:0]  c;
      shift_ir(4'b0010, c);
      for (int k = 0; k < 2; k++) begin
         shift_dr(32, {33'h0, 32'hFFFF_0000}, d);
         checks++;
         if (d[31:0] !== 32'h1010_2001) begin
            failures++;
            $display("FAIL idcode_b2b%0d got=%h exp=10102001", k, d[31:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass(4'b1111);
      test_bypass(4'b1010);
      test_confreg();
      test_mem_rw();
      test_mem_alias_rst();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
